// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing one APB slave port among NUM_REQ requesters, with wait-state timeout
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      timeout_evt,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, rr_nxt, gnt, gnt_nxt, arb_idx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic any_req;
  logic [NUM_REQ-1:0] req_ready_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0] rdata_nxt, pwdata_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic err_nxt, timeout_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  function automatic int wrap(input int v);
    return v >= NUM_REQ ? v - NUM_REQ : v;
  endfunction
  always_comb begin
    any_req = 1'b0;
    arb_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[PW'(wrap(int'(rr_ptr) + k))]) begin
        any_req = 1'b1;
        arb_idx = PW'(wrap(int'(rr_ptr) + k));
      end
    end
  end
  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    gnt_nxt       = gnt;
    cnt_nxt       = cnt;
    req_ready_nxt = '0;
    rsp_valid_nxt = '0;
    timeout_nxt   = 1'b0;
    rdata_nxt     = rsp_rdata;
    err_nxt       = rsp_err;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    case (state)
      IDLE: if (any_req) begin
        state_nxt     = SETUP;
        gnt_nxt       = arb_idx;
        rr_nxt        = PW'(wrap(int'(arb_idx) + 1));
        req_ready_nxt = NUM_REQ'(1) << arb_idx;
        psel_nxt      = 1'b1;
        penable_nxt   = 1'b0;
        pwrite_nxt    = req_write[arb_idx];
        paddr_nxt     = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        pwdata_nxt    = req_write[arb_idx] ? req_wdata[int'(arb_idx)*DATA_W +: DATA_W] : '0;
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: if (pready || cnt == CW'(TIMEOUT - 1)) begin
        state_nxt     = IDLE;
        rsp_valid_nxt = NUM_REQ'(1) << gnt;
        rdata_nxt     = pready && !pwrite ? prdata : '0;
        err_nxt       = pready ? pslverr : 1'b1;
        timeout_nxt   = !pready;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt         <= '0;
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      timeout_evt <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      gnt         <= gnt_nxt;
      cnt         <= cnt_nxt;
      req_ready   <= req_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rdata_nxt;
      rsp_err     <= err_nxt;
      timeout_evt <= timeout_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and randomized checks of apb_req_arbiter against a transaction-level model
module tb_apb_req_arbiter;
  localparam int N = 3, AW = 32, DW = 32, TO = 16;
  logic pclk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic rsp_err, timeout_evt, psel, penable, pwrite, pready, pslverr;
  bit rv[N];
  bit rw[N];
  logic [31:0] ra[N];
  logic [31:0] rd[N];
  logic [31:0] mem [logic [31:0]];
  int rr, passed, total;
  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .timeout_evt(timeout_evt), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );
  always #5 pclk = ~pclk;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rv[i];
      req_write[i] = rw[i];
      req_addr[i*AW +: AW] = ra[i];
      req_wdata[i*DW +: DW] = rd[i];
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  function automatic int pick();
    for (int k = 0; k < N; k++) if (rv[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] oh(input int g);
    return N'(1) << g;
  endfunction
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  task automatic idle_step();
    step();
    chk("idle_psel", psel, 0);
    chk("idle_req_ready", req_ready, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_timeout_evt", timeout_evt, 0);
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    rr = 0;
    #2;
    chk("rst_psel_penable", {psel, penable, pwrite}, 0);
    chk("rst_ready_valid", {req_ready, rsp_valid, rsp_err, timeout_evt}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata_rdata", {pwdata, rsp_rdata}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    idle_step();
  endtask
  task automatic run_txn(input int waits, input bit err);
    int g;
    logic [31:0] a, wd, pd;
    bit w, to;
    g = pick();
    rr = (g + 1) % N;
    a = ra[g];
    w = rw[g];
    wd = rd[g];
    pready = 1'($urandom);
    pslverr = 1'b1;
    prdata = $urandom;
    step();
    chk("grant_req_ready", req_ready, oh(g));
    chk("grant_psel_penable", {psel, penable}, 2'b10);
    chk("grant_paddr", paddr, a);
    chk("grant_pwrite", pwrite, w);
    chk("grant_pwdata", pwdata, w ? wd : 32'h0);
    chk("grant_rsp_clear", {rsp_valid, timeout_evt}, 0);
    rv[g] = 1'b0;
    step();
    chk("access_penable", {psel, penable, req_ready}, {2'b11, N'(0)});
    to = 1'b0;
    pd = '0;
    for (int i = 0; ; i++) begin
      pready = i >= waits;
      pslverr = pready ? err : 1'($urandom);
      pd = w ? $urandom : mrd(a);
      prdata = pd;
      step();
      if (i >= waits) break;
      if (i == TO - 1) begin
        to = 1'b1;
        break;
      end
      chk("wait_hold", {psel, penable, rsp_valid, paddr}, {2'b11, N'(0), a});
    end
    chk("done_rsp_valid", rsp_valid, oh(g));
    chk("done_rsp_err", rsp_err, to | err);
    chk("done_rsp_rdata", rsp_rdata, (to || w) ? 32'h0 : pd);
    chk("done_timeout_evt", timeout_evt, to);
    chk("done_psel_penable", {psel, penable}, 0);
    chk("done_held", {pwrite, paddr}, {w, a});
    if (!to && !err && w) mem[a] = wd;
    pready = 1'b0;
    pslverr = 1'b0;
  endtask
  task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    rv[i] = 1'b1;
    rw[i] = w;
    ra[i] = a;
    rd[i] = d;
  endtask
  initial begin
    passed = 0;
    total = 0;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    #3;
    reset_dut();
    set_req(0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    run_txn(0, 1'b0);
    set_req(0, 1'b0, 32'h4, 32'h0);
    run_txn(0, 1'b0);
    chk("readback_4", rsp_rdata, 32'hDEAD_BEEF);
    reset_dut();
    mem[32'h8] = 32'hFACE_5678;
    set_req(1, 1'b0, 32'h8, 32'h0);
    run_txn(3, 1'b0);
    chk("wait3_rdata", rsp_rdata, 32'hFACE_5678);
    reset_dut();
    repeat (2) begin
      set_req(0, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 32'hC, 32'h0);
      run_txn(0, 1'b0);
      chk("pair_first_was_0", {28'h0, rv[1], rv[0]}, 2'b10);
      run_txn(0, 1'b0);
    end
    idle_step();
    set_req(0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    run_txn(0, 1'b1);
    idle_step();
    set_req(2, 1'b0, 32'h10, 32'h0);
    run_txn(TO, 1'b0);
    idle_step();
    reset_dut();
    set_req(0, 1'b0, 32'h10, 32'h0);
    run_txn(0, 1'b0);
    set_req(1, 1'b1, 32'h14, 32'h1234_5678);
    step();
    chk("pre_rst_grant", req_ready, oh(1));
    rv[1] = 1'b0;
    step();
    step();
    chk("pre_rst_access", {psel, penable}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {psel, penable, req_ready, rsp_valid}, 0);
    rr = 0;
    step();
    rst_n = 1'b1;
    idle_step();
    idle_step();
    set_req(1, 1'b0, 32'h14, 32'h0);
    set_req(0, 1'b0, 32'h4, 32'h0);
    run_txn(0, 1'b0);
    run_txn(1, 1'b0);
    chk("killed_write_dropped", rsp_rdata, 32'h0);
    repeat (150) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), 32'($urandom_range(0, 7)) << 2, $urandom);
      if (pick() < 0) idle_step();
      else begin
        int r;
        r = $urandom_range(0, 19);
        run_txn(r == 19 ? TO + r % 3 : r % 5, $urandom_range(0, 5) == 0);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Multi-requester APB master that shares one APB slave port (e.g. the register/memory slave) between NUM_REQ local requesters. It arbitrates round-robin and sequences each accepted request through APB SETUP/ACCESS phases. It returns read data and error status to the owning requester, and terminates hung transfers with a wait-state timeout.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max consecutive ACCESS cycles with pready=0 before forced termination (>=1)

Ports:
pclk  in  1  APB clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held with fields stable until req_ready seen
req_write  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to owner
rsp_rdata  out  DATA_W  read data of completed transfer
rsp_err  out  1  completion error (pslverr or timeout)
timeout_evt  out  1  one-cycle pulse when a transfer is killed by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data (0 on reads)
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; RR pointer=0; wait counter=0. In-flight transfer dropped, no rsp_valid issued. Outputs stay 0 until first edge after rst_n rises.
- All outputs registered. FSM states: IDLE, SETUP, ACCESS.
- IDLE: arbitration only here. At an edge with any req_valid, grant g = first set bit searching from RR pointer upward, wrapping modulo NUM_REQ. Latch req_write/addr/wdata of g; next cycle req_ready[g]=1, psel=1, penable=0, state SETUP. RR pointer <= (g+1) mod NUM_REQ. No req_valid -> stay IDLE, pointer unchanged.
- SETUP: one cycle. Next edge: penable=1, state ACCESS, wait counter cleared. req_ready returns to 0.
- ACCESS, sampled each edge:
  - pready=1: capture rsp_rdata=prdata (reads; 0 for writes), rsp_err=pslverr; next cycle rsp_valid[g]=1, psel=penable=0, paddr/pwdata/pwrite held, state IDLE.
  - pready=0 and counter==TIMEOUT-1: terminate. rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, timeout_evt=1, psel=penable=0, state IDLE.
  - Otherwise counter++, hold all APB outputs.
- Timing: zero-wait transfer = 3 cycles from acceptance edge to IDLE. req_ready to rsp_valid = 2 + wait cycles.
- Arbitration may occur on the same edge that rsp_valid is asserted (state IDLE). Back-to-back transfers therefore have psel low for exactly one cycle.
- Requester contract: drop or advance req_valid by the edge after req_ready. A still-asserted req_valid is treated as a new request.
- rsp_rdata/rsp_err hold until next completion; meaningful only with rsp_valid.
- Simultaneous req_valid from all requesters: served in strict rotation, no starvation; max wait = NUM_REQ-1 transfers.
- pslverr ignored outside ACCESS with pready=1.

Test Plan:
- Req0 write addr 0x4 data 0xDEAD_BEEF, pready tied 1 -> req_ready[0] cycle 1, psel=1/penable=0 cycle 1, penable=1 cycle 2, rsp_valid[0]=1 cycle 3, rsp_err=0; read-back of 0x4 returns 0xDEAD_BEEF.
- Req1 read addr 0x8 after reset, slave inserts 3 wait states -> psel/penable held 3 extra cycles, rsp_valid[1] with rsp_rdata=0xFACE_5678.
- Req0 and req1 asserted same cycle from reset, reads of 0x0 and 0xC -> grant order 0 then 1, then next pair 0,1; psel low exactly one cycle between transfers.
- Req0 read addr 0xFFFF_FFFF, slave asserts pslverr with pready -> rsp_valid[0], rsp_err=1, timeout_evt=0.
- pready held 0, TIMEOUT=16 -> termination after 16 ACCESS cycles: rsp_err=1, rsp_rdata=0, timeout_evt one-cycle pulse, psel=0.
- rst_n pulsed low during ACCESS -> psel/penable/req_ready/rsp_valid 0 immediately, no rsp_valid after release, next grant to requester 0.
